lab4_branch_branch_pred_ctrl: RTL and testbench

LAB4_BRANCH_BRANCH_PRED_CTRL -- requirements
Module: lab4_branch_BranchPredCtrl

---
 rtl/lab4_branch_branch_pred_ctrl.sv | 149 ++++++++++++++
 tb/tb_lab4_branch_branch_pred_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab4_branch_branch_pred_ctrl.sv
// ---------------------------------------------------------------------------
// lab4_branch_branch_pred_ctrl
//
// Purpose: sits between instruction fetch and a gshare predictor. Fetch
// lookups are forwarded to the predictor and the prediction comes back as a
// registered response one cycle later. Every predicted branch is kept in a
// small in-flight queue until the back end resolves it. A resolve trains
// the predictor and pops the oldest entry. A wrong prediction pulses
// mispredict and flushes all younger entries.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   req_val/req_rdy/req_pc      fetch-side lookup request
//   resp_val/resp_rdy/resp_taken registered prediction response
//   resolve_val/resolve_rdy/resolve_taken  outcome of oldest in-flight branch
//   mispredict                  one-cycle pulse after a wrong prediction
//   pred_pc, pred_update_en, pred_update_val, pred_prediction
//                               shared port to the gshare predictor
//   num_branches, num_mispredicts  wrapping 32-bit statistics counters
//   o_dbg_count                 current queue occupancy (observation only)
//
// Handshakes: every channel uses strict valid/ready. A transfer happens on a
// rising clock edge where valid and ready are both 1. A producer holds valid
// and its payload stable until that transfer. The ready signals here depend
// on the opposite valid only where the predictor PC port is shared: a
// pending resolve takes the port, so req_rdy drops while resolve_val is high.
// ---------------------------------------------------------------------------
module lab4_branch_branch_pred_ctrl #(
    parameter int NUM_ENTRIES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_val,
    output logic                          req_rdy,
    input  logic [31:0]                   req_pc,
    output logic                          resp_val,
    input  logic                          resp_rdy,
    output logic                          resp_taken,
    input  logic                          resolve_val,
    output logic                          resolve_rdy,
    input  logic                          resolve_taken,
    output logic                          mispredict,
    output logic [31:0]                   pred_pc,
    output logic                          pred_update_en,
    output logic                          pred_update_val,
    input  logic                          pred_prediction,
    output logic [31:0]                   num_branches,
    output logic [31:0]                   num_mispredicts,
    output logic [$clog2(NUM_ENTRIES):0]  o_dbg_count
);

    localparam int PW = $clog2(NUM_ENTRIES);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(NUM_ENTRIES);

    // In-flight queue storage: PC and the prediction that was handed out.
    logic [31:0]   r_pc   [NUM_ENTRIES];
    logic          r_pred [NUM_ENTRIES];

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_resp_val;
    logic          r_resp_taken;
    logic          r_mispredict;
    logic [31:0]   r_num_branches;
    logic [31:0]   r_num_mispredicts;

    logic          w_req_fire;
    logic          w_resolve_fire;
    logic          w_resp_fire;
    logic          w_head_pred;
    logic          w_wrong;

    // A new request may only issue if the response slot will be free at the
    // next edge, so the registered response is never overwritten unseen.
    assign req_rdy     = (r_count < FULL_COUNT) && (!r_resp_val || resp_rdy) && !resolve_val;
    // Holding resolves off while a response is pending guarantees the branch
    // being resolved has already been seen by fetch.
    assign resolve_rdy = (r_count != '0) && !r_resp_val;

    assign w_req_fire     = req_val && req_rdy;
    assign w_resolve_fire = resolve_val && resolve_rdy;
    assign w_resp_fire    = r_resp_val && resp_rdy;

    assign w_head_pred = r_pred[r_head];
    assign w_wrong     = w_resolve_fire && (resolve_taken != w_head_pred);

    // The predictor PC port is shared: training uses the resolved branch's PC.
    assign pred_pc         = w_resolve_fire ? r_pc[r_head] : req_pc;
    assign pred_update_en  = w_resolve_fire;
    assign pred_update_val = w_resolve_fire && resolve_taken;

    assign resp_val        = r_resp_val;
    assign resp_taken      = r_resp_taken;
    assign mispredict      = r_mispredict;
    assign num_branches    = r_num_branches;
    assign num_mispredicts = r_num_mispredicts;
    assign o_dbg_count     = r_count;

    // Entry payload needs no reset: it is only read while count > 0.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_pc[r_tail]   <= req_pc;
            r_pred[r_tail] <= pred_prediction;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head            <= '0;
            r_tail            <= '0;
            r_count           <= '0;
            r_resp_val        <= 1'b0;
            r_resp_taken      <= 1'b0;
            r_mispredict      <= 1'b0;
            r_num_branches    <= '0;
            r_num_mispredicts <= '0;
        end else begin
            r_mispredict <= w_wrong;

            // req fire and resolve fire never coincide (req_rdy needs !resolve_val).
            if (w_resolve_fire) begin
                r_num_branches <= r_num_branches + 32'd1;
                if (w_wrong) begin
                    // Everything younger was fetched down the wrong path.
                    r_num_mispredicts <= r_num_mispredicts + 32'd1;
                    r_head            <= '0;
                    r_tail            <= '0;
                    r_count           <= '0;
                end else begin
                    r_head  <= r_head + PW'(1);
                    r_count <= r_count - CW'(1);
                end
            end else if (w_req_fire) begin
                r_tail  <= r_tail + PW'(1);
                r_count <= r_count + CW'(1);
            end

            if (w_req_fire) begin
                r_resp_val   <= 1'b1;
                r_resp_taken <= pred_prediction;
            end else if (w_resp_fire) begin
                r_resp_val <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lab4_branch_branch_pred_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lab4_branch_branch_pred_ctrl
//
// Bench for the branch prediction controller. The reference model keeps the
// in-flight branches as a queue of {pc, prediction} records and applies the
// controller's rules to it once per clock cycle.
// ---------------------------------------------------------------------------
module tb_lab4_branch_branch_pred_ctrl;

    localparam int N = 4;

    logic        clk;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [31:0] req_pc;
    logic        resp_val;
    logic        resp_rdy;
    logic        resp_taken;
    logic        resolve_val;
    logic        resolve_rdy;
    logic        resolve_taken;
    logic        mispredict;
    logic [31:0] pred_pc;
    logic        pred_update_en;
    logic        pred_update_val;
    logic        pred_prediction;
    logic [31:0] num_branches;
    logic [31:0] num_mispredicts;
    logic [2:0]  o_dbg_count;

    lab4_branch_branch_pred_ctrl #(.NUM_ENTRIES(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_val         (req_val),
        .req_rdy         (req_rdy),
        .req_pc          (req_pc),
        .resp_val        (resp_val),
        .resp_rdy        (resp_rdy),
        .resp_taken      (resp_taken),
        .resolve_val     (resolve_val),
        .resolve_rdy     (resolve_rdy),
        .resolve_taken   (resolve_taken),
        .mispredict      (mispredict),
        .pred_pc         (pred_pc),
        .pred_update_en  (pred_update_en),
        .pred_update_val (pred_update_val),
        .pred_prediction (pred_prediction),
        .num_branches    (num_branches),
        .num_mispredicts (num_mispredicts),
        .o_dbg_count     (o_dbg_count)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [32:0] exp_q[$];          // {pc, prediction}, oldest first
    logic        m_rv;
    logic        m_rt;
    logic [31:0] m_nb;
    logic [31:0] m_nm;
    int          n_pass;
    int          n_fail;
    int          n_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rv = 1'b0;
        m_rt = 1'b0;
        m_nb = 32'd0;
        m_nm = 32'd0;
    endtask

    task automatic drive(input logic rv, input logic [31:0] pc, input logic pp,
                         input logic rr, input logic sv, input logic st);
        req_val         = rv;
        req_pc          = pc;
        pred_prediction = pp;
        resp_rdy        = rr;
        resolve_val     = sv;
        resolve_taken   = st;
    endtask

    // One clock cycle with the inputs already driven: check the combinational
    // outputs, advance the model, then check the registered outputs.
    task automatic cycle();
        logic        e_req_rdy;
        logic        e_res_rdy;
        logic        rqf;
        logic        rsf;
        logic        mis;
        logic [32:0] e;
        logic [31:0] e_pc;
        #1;
        e_req_rdy = (exp_q.size() < N) && (!m_rv || resp_rdy) && !resolve_val;
        e_res_rdy = (exp_q.size() > 0) && !m_rv;
        chk("req_rdy", 32'(req_rdy), 32'(e_req_rdy));
        chk("resolve_rdy", 32'(resolve_rdy), 32'(e_res_rdy));
        rqf  = req_val && e_req_rdy;
        rsf  = resolve_val && e_res_rdy;
        e_pc = req_pc;
        if (rsf) e_pc = exp_q[0][32:1];
        chk("pred_pc", pred_pc, e_pc);
        chk("pred_update_en", 32'(pred_update_en), 32'(rsf));
        if (rsf) chk("pred_update_val", 32'(pred_update_val), 32'(resolve_taken));

        mis = 1'b0;
        if (rsf) begin
            e = exp_q.pop_front();
            m_nb++;
            if (e[0] != resolve_taken) begin
                mis = 1'b1;
                m_nm++;
                exp_q.delete();
            end
        end else if (rqf) begin
            exp_q.push_back({req_pc, pred_prediction});
        end
        if (rqf) begin
            m_rv = 1'b1;
            m_rt = pred_prediction;
        end else if (m_rv && resp_rdy) begin
            m_rv = 1'b0;
        end

        @(posedge clk);
        #1;
        chk("resp_val", 32'(resp_val), 32'(m_rv));
        if (m_rv) chk("resp_taken", 32'(resp_taken), 32'(m_rt));
        chk("mispredict", 32'(mispredict), 32'(mis));
        chk("num_branches", num_branches, m_nb);
        chk("num_mispredicts", num_mispredicts, m_nm);
        chk("count", 32'(o_dbg_count), 32'(exp_q.size()));
    endtask

    initial begin
        logic st;
        n_pass  = 0;
        n_fail  = 0;
        n_total = 0;
        model_reset();
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        #3;
        chk("rst_resp_val", 32'(resp_val), 32'd0);
        chk("rst_resp_taken", 32'(resp_taken), 32'd0);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        chk("rst_num_branches", num_branches, 32'd0);
        chk("rst_num_mispredicts", num_mispredicts, 32'd0);
        chk("rst_count", 32'(o_dbg_count), 32'd0);
        chk("rst_resolve_rdy", 32'(resolve_rdy), 32'd0);
        chk("rst_update_en", 32'(pred_update_en), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        // First request: one-cycle response latency
        drive(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("first_resp_val", 32'(resp_val), 32'd1);
        chk("first_resp_taken", 32'(resp_taken), 32'd1);
        chk("first_count", 32'(o_dbg_count), 32'd1);

        // Fill the queue; the fifth request must stall
        drive(1'b1, 32'h104, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h108, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h10C, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("full_req_rdy", 32'(req_rdy), 32'd0);
        chk("full_count", 32'(o_dbg_count), 32'd4);
        drive(1'b1, 32'h110, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("stall_count", 32'(o_dbg_count), 32'd4);

        // Request and resolve together: resolve wins the predictor port
        drive(1'b1, 32'h110, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        chk("both_pred_pc", pred_pc, 32'h100);
        chk("both_req_rdy", 32'(req_rdy), 32'd0);
        chk("both_update_val", 32'(pred_update_val), 32'd1);
        cycle();
        chk("correct_mispredict", 32'(mispredict), 32'd0);
        chk("correct_num_branches", num_branches, 32'd1);
        chk("correct_count", 32'(o_dbg_count), 32'd3);
        drive(1'b1, 32'h110, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("after_resolve_count", 32'(o_dbg_count), 32'd4);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();

        // 0x104 resolves correctly, then 0x108 (predicted 0) mispredicts
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("mis_pred_pc", pred_pc, 32'h108);
        cycle();
        chk("mis_pulse", 32'(mispredict), 32'd1);
        chk("mis_num_mispredicts", num_mispredicts, 32'd1);
        chk("mis_count", 32'(o_dbg_count), 32'd0);
        chk("mis_resolve_rdy", 32'(resolve_rdy), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        chk("mis_pulse_end", 32'(mispredict), 32'd0);

        // Asynchronous reset between edges with two entries and a pending response
        drive(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h204, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("pre_rst_count", 32'(o_dbg_count), 32'd2);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("arst_resp_val", 32'(resp_val), 32'd0);
        chk("arst_count", 32'(o_dbg_count), 32'd0);
        chk("arst_resolve_rdy", 32'(resolve_rdy), 32'd0);
        chk("arst_num_branches", num_branches, 32'd0);
        chk("arst_num_mispredicts", num_mispredicts, 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        chk("post_rst_count", 32'(o_dbg_count), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            st = 1'($urandom_range(0, 1));
            if (exp_q.size() > 0)
                st = ($urandom_range(0, 3) != 0) ? exp_q[0][0] : ~exp_q[0][0];
            drive(($urandom_range(0, 9) < 6), $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4), st);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
